bp_table_ctrl: RTL and testbench
================================

// Module: bp_table_ctrl
// PURPOSE
//  Sequences the single-port local branch-prediction counter table (2^IDX_W x CTR_W SRAM/regfile).
//  Shares the port between fetch-stage lookups and execute-stage read-modify-write updates.
//  Runs a post-reset table initialisation sweep. Sits beside ghr; its index input already folds in local_src.
// PARAMETERS
//  IDX_W      5      table index width (2^IDX_W entries)
//  CTR_W      2      saturating counter width; MSB = predict taken
//  UPD_DEPTH  2      pending-update FIFO depth (>=1)
//  INIT_VAL   2'b01  value written to every entry during init (weakly untaken)
// PORTS
//  clk_i            in   1      clock, rising edge
//  reset_n_i        in   1      async active-low reset
//  stall_e_i        in   1      execute stall
//  branch_op_e_i    in   2      [0]=conditional branch in E
//  pc_src_res_e_i   in   1      resolved branch outcome (1=taken)
//  upd_idx_e_i      in   IDX_W  table index of the E-stage branch
//  lookup_vld_f_i   in   1      fetch lookup request
//  lookup_idx_f_i   in   IDX_W  fetch lookup index
//  lookup_gnt_o     out  1      lookup accepted this cycle
//  pred_vld_o       out  1      pred_taken_o valid (1 cycle after grant)
//  pred_taken_o     out  1      MSB of the counter read
//  busy_o           out  1      init sweep in progress
//  tbl_en_o         out  1      table port enable
//  tbl_we_o         out  1      table write enable
//  tbl_addr_o       out  IDX_W  table address
//  tbl_wdata_o      out  CTR_W  table write data
//  tbl_rdata_i      in   CTR_W  table read data, valid cycle after en & ~we
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=INIT, init_addr=0, FIFO empty; all outputs 0 except busy_o=1.
//  Reset asserted mid-op: everything aborts, sweep restarts at 0; in-flight updates are lost.
//  FSM states:
//   INIT: write INIT_VAL to addr init_addr, one entry/cycle; at addr 2^IDX_W-1 go to RUN.
//     Sweep takes 2^IDX_W cycles. lookup_gnt_o=0. E updates discarded, not queued.
//   RUN: arbitration (one port op/cycle), priority order:
//     1) UPD_WR: write the saturated counter for the update read in the previous cycle.
//     2) FIFO full: issue update read (anti-starvation), lookup_gnt_o=0.
//     3) lookup_vld_f_i: read lookup_idx_f_i, lookup_gnt_o=1.
//     4) FIFO non-empty: issue update read (pop head).
//   An update read is always followed next cycle by its UPD_WR (RMW = 2 cycles, non-interruptible).
//  Update capture: push {upd_idx_e_i, pc_src_res_e_i} when branch_op_e_i[0] & ~stall_e_i & RUN.
//   Push and pop in the same cycle on a full FIFO: pop first, push accepted.
//   Push on full with no pop: update dropped silently.
//  Counter arithmetic: taken -> min(ctr+1, 2^CTR_W-1); untaken -> max(ctr-1, 0). No wrap.
//  Lookup: pred_vld_o=1 exactly one cycle after lookup_gnt_o, pred_taken_o=tbl_rdata_i[CTR_W-1];
//   otherwise pred_vld_o=0, pred_taken_o=0.
//  Ordering/hazards:
//   Lookup to an index with a queued or in-flight update returns the pre-update value.
//   Two queued updates to the same index apply in order; the second RMW reads the first's result.
//  tbl_wdata_o=0 whenever tbl_we_o=0. tbl_addr_o holds the last value when tbl_en_o=0.
// CONFIGURATION
//  BP_TABLE_STATS_EN defined: adds outputs upd_cnt_o[15:0] (completed UPD_WR writes) and
//   drop_cnt_o[15:0] (dropped pushes). Both saturate at 16'hFFFF, reset to 0, do not count during INIT.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Init: release reset, IDX_W=5 -> 32 writes of 2'b01 at addrs 0..31, busy_o=0 at cycle 33, no gnt before.
//  Saturation: 4 taken updates to idx 3 -> final writes 10,11,11,11; lookup idx 3 -> pred_taken_o=1.
//  Arbitration: lookup_vld every cycle + 1 update -> lookup granted until FIFO full, then RD/WR.
//   Lookup stalls at most 2 cycles per update.
//  Overflow: UPD_DEPTH=2, 3 back-to-back pushes while FIFO full and no pop -> 3rd dropped.
//   With BP_TABLE_STATS_EN, drop_cnt_o=1.
//  Stall/op gating: branch_op_e_i=2'b01 with stall_e_i=1, or branch_op_e_i[0]=0 -> no push, no table write.
//  Reset mid-sweep at init_addr=17 -> after release, sweep restarts at addr 0, full 32 cycles.

Source files
------------

// File: rtl/bp_table_ctrl.sv
// Local branch-prediction counter table sequencer: init sweep, fetch lookups, E-stage RMW updates.
// Optional BP_TABLE_STATS_EN adds completed-update and dropped-update counters.
module bp_table_ctrl #(
  parameter int unsigned     IDX_W     = 5,
  parameter int unsigned     CTR_W     = 2,
  parameter int unsigned     UPD_DEPTH = 2,
  parameter logic [CTR_W-1:0] INIT_VAL = CTR_W'(1)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             stall_e_i,
  input  logic [1:0]       branch_op_e_i,
  input  logic             pc_src_res_e_i,
  input  logic [IDX_W-1:0] upd_idx_e_i,
  input  logic             lookup_vld_f_i,
  input  logic [IDX_W-1:0] lookup_idx_f_i,
  output logic             lookup_gnt_o,
  output logic             pred_vld_o,
  output logic             pred_taken_o,
  output logic             busy_o,
  output logic             tbl_en_o,
  output logic             tbl_we_o,
  output logic [IDX_W-1:0] tbl_addr_o,
  output logic [CTR_W-1:0] tbl_wdata_o,
  input  logic [CTR_W-1:0] tbl_rdata_i
`ifdef BP_TABLE_STATS_EN
  ,
  output logic [15:0]      upd_cnt_o,
  output logic [15:0]      drop_cnt_o
`endif
);

  localparam int unsigned PTR_W    = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(UPD_DEPTH + 1);
  localparam int unsigned TBL_LAST = (1 << IDX_W) - 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_t;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_addr;
  upd_t             fifo_mem [UPD_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             upd_rd_q, upd_wr_q, upd_taken_q;

  logic fifo_full, fifo_empty, push, pop, push_ok;
  upd_t head;
  logic [CTR_W-1:0] wr_val;
  logic unused_op_hi;

  function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] ctr, input logic taken);
    logic [CTR_W-1:0] res;
    if (taken) res = (ctr == '1) ? ctr : ctr + CTR_W'(1);
    else       res = (ctr == '0) ? ctr : ctr - CTR_W'(1);
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(UPD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign unused_op_hi = branch_op_e_i[1];
  assign fifo_full    = (count == CNT_W'(UPD_DEPTH));
  assign fifo_empty   = (count == '0);
  assign head         = fifo_mem[rd_ptr];
  assign push         = (state == ST_RUN) & branch_op_e_i[0] & ~stall_e_i;
  // Pop mirrors the arbitration below: full FIFO beats lookups, a pending UPD_WR beats both.
  assign pop          = (state == ST_RUN) & ~upd_rd_q & ~fifo_empty & (fifo_full | ~lookup_vld_f_i);
  assign push_ok      = push & (~fifo_full | pop);

  // Write data comes straight off the read port in the UPD_WR cycle so the RMW stays 2 cycles.
  assign wr_val       = sat_step(tbl_rdata_i, upd_taken_q);
  assign tbl_wdata_o  = !tbl_we_o ? '0 : (upd_wr_q ? wr_val : INIT_VAL);
  assign pred_taken_o = pred_vld_o & tbl_rdata_i[CTR_W-1];

  // Pending-update FIFO
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(UPD_DEPTH); i++) fifo_mem[i] <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= '{idx: upd_idx_e_i, taken: pc_src_res_e_i};
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  // Sequencer: init sweep, then one table op per cycle with registered port controls
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= ST_INIT;
      init_addr    <= '0;
      busy_o       <= 1'b1;
      tbl_en_o     <= 1'b0;
      tbl_we_o     <= 1'b0;
      tbl_addr_o   <= '0;
      lookup_gnt_o <= 1'b0;
      pred_vld_o   <= 1'b0;
      upd_rd_q     <= 1'b0;
      upd_wr_q     <= 1'b0;
      upd_taken_q  <= 1'b0;
    end else begin
      tbl_en_o     <= 1'b0;
      tbl_we_o     <= 1'b0;
      lookup_gnt_o <= 1'b0;
      upd_rd_q     <= 1'b0;
      upd_wr_q     <= 1'b0;
      pred_vld_o   <= lookup_gnt_o;
      case (state)
        ST_INIT: begin
          busy_o     <= 1'b1;
          tbl_en_o   <= 1'b1;
          tbl_we_o   <= 1'b1;
          tbl_addr_o <= init_addr;
          init_addr  <= init_addr + IDX_W'(1);
          if (init_addr == IDX_W'(TBL_LAST)) state <= ST_RUN;
        end
        default: begin
          busy_o <= 1'b0;
          if (upd_rd_q) begin
            tbl_en_o <= 1'b1;
            tbl_we_o <= 1'b1;
            upd_wr_q <= 1'b1;
          end else if (fifo_full || (!lookup_vld_f_i && !fifo_empty)) begin
            tbl_en_o    <= 1'b1;
            tbl_addr_o  <= head.idx;
            upd_taken_q <= head.taken;
            upd_rd_q    <= 1'b1;
          end else if (lookup_vld_f_i) begin
            tbl_en_o     <= 1'b1;
            tbl_addr_o   <= lookup_idx_f_i;
            lookup_gnt_o <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef BP_TABLE_STATS_EN
  // Saturating activity counters, RUN state only
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      upd_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else if (state == ST_RUN) begin
      if (upd_wr_q && upd_cnt_o != 16'hFFFF) upd_cnt_o <= upd_cnt_o + 16'd1;
      if (push && !push_ok && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Scoreboard bench for bp_table_ctrl: table model, expected writes and predictions queued at stimulus time.
module tb_bp_table_ctrl;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CTR_W = 2;
  localparam int unsigned N_ENT = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset_n_i;
  logic             stall_e_i;
  logic [1:0]       branch_op_e_i;
  logic             pc_src_res_e_i;
  logic [IDX_W-1:0] upd_idx_e_i;
  logic             lookup_vld_f_i;
  logic [IDX_W-1:0] lookup_idx_f_i;
  logic             lookup_gnt_o, pred_vld_o, pred_taken_o, busy_o;
  logic             tbl_en_o, tbl_we_o;
  logic [IDX_W-1:0] tbl_addr_o;
  logic [CTR_W-1:0] tbl_wdata_o;
  logic [CTR_W-1:0] tbl_rdata_i;
`ifdef BP_TABLE_STATS_EN
  logic [15:0]      upd_cnt_o, drop_cnt_o;
`endif

  bp_table_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .stall_e_i(stall_e_i), .branch_op_e_i(branch_op_e_i),
    .pc_src_res_e_i(pc_src_res_e_i), .upd_idx_e_i(upd_idx_e_i), .lookup_vld_f_i(lookup_vld_f_i),
    .lookup_idx_f_i(lookup_idx_f_i), .lookup_gnt_o(lookup_gnt_o), .pred_vld_o(pred_vld_o),
    .pred_taken_o(pred_taken_o), .busy_o(busy_o), .tbl_en_o(tbl_en_o), .tbl_we_o(tbl_we_o),
    .tbl_addr_o(tbl_addr_o), .tbl_wdata_o(tbl_wdata_o), .tbl_rdata_i(tbl_rdata_i)
`ifdef BP_TABLE_STATS_EN
    , .upd_cnt_o(upd_cnt_o), .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int n_acc = 0;
  logic             mon_en = 1'b0;
  logic             prev_gnt = 1'b0;
  logic [IDX_W-1:0] lk_idx = '0;
  logic [CTR_W-1:0] mem [N_ENT];
  logic [CTR_W-1:0] ref_mem [N_ENT];
  logic [CTR_W-1:0] vis_mem [N_ENT];
  logic             pred_q [$];
  logic [IDX_W+CTR_W-1:0] wr_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Synchronous single-port table model
  always @(posedge clk) begin
    if (tbl_en_o) begin
      if (tbl_we_o) mem[tbl_addr_o] <= tbl_wdata_o;
      else          tbl_rdata_i     <= mem[tbl_addr_o];
    end
  end

  // Output monitor: predictions and table writes against the scoreboard queues
  always @(negedge clk) begin
    if (mon_en) begin
      if (pred_vld_o) begin
        if (pred_q.size() == 0) check("pred_unexpected", 32'(pred_vld_o), 32'd0);
        else                    check("pred_taken", 32'(pred_taken_o), 32'(pred_q.pop_front()));
      end else if (pred_taken_o) check("pred_taken_idle", 32'(pred_taken_o), 32'd0);
      if (pred_vld_o != prev_gnt) check("pred_vld_latency", 32'(pred_vld_o), 32'(prev_gnt));
      prev_gnt = lookup_gnt_o;
      if (lookup_gnt_o) begin
        check("lookup_port", {tbl_en_o, tbl_we_o, tbl_addr_o}, {1'b1, 1'b0, lk_idx});
        pred_q.push_back(vis_mem[lk_idx][CTR_W-1]);
      end
      if (tbl_en_o && tbl_we_o) begin
        n_wr++;
        if (wr_q.size() == 0) check("upd_wr_unexpected", {tbl_addr_o, tbl_wdata_o}, 32'hFFFF);
        else                  check("upd_wr", {tbl_addr_o, tbl_wdata_o}, 32'(wr_q.pop_front()));
      end
      if (!tbl_we_o && tbl_wdata_o != '0) check("wdata_no_we", 32'(tbl_wdata_o), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_e_i = 1'b0; branch_op_e_i = 2'b00; pc_src_res_e_i = 1'b0;
    upd_idx_e_i = '0; lookup_vld_f_i = 1'b0;
  endtask

  // Drive an update for the next edge; accepted ones get their expected write queued
  task automatic push_upd(input logic [IDX_W-1:0] idx, input logic taken, input logic accept);
    branch_op_e_i = 2'b01; stall_e_i = 1'b0; upd_idx_e_i = idx; pc_src_res_e_i = taken;
    if (accept) begin
      ref_mem[idx] = ctr_next(ref_mem[idx], taken);
      wr_q.push_back({idx, ref_mem[idx]});
      n_acc++;
    end
  endtask

  task automatic drain();
    clear_inputs();
    repeat (12) tick();
    for (int i = 0; i < int'(N_ENT); i++) vis_mem[i] = ref_mem[i];
  endtask

  task automatic lookup(input logic [IDX_W-1:0] idx, input int n);
    lk_idx = idx; lookup_idx_f_i = idx; lookup_vld_f_i = 1'b1;
    repeat (n) tick();
    lookup_vld_f_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic check_reset_outs();
    check("reset_outputs",
          {busy_o, tbl_en_o, tbl_we_o, tbl_addr_o, tbl_wdata_o, lookup_gnt_o, pred_vld_o, pred_taken_o},
          {1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0});
  endtask

  // Sweep check for n cycles after reset release; full sweeps also check busy drop on cycle 33
  task automatic run_init(input int n);
    for (int c = 1; c <= n; c++) begin
      tick();
      check("init_cycle", {lookup_gnt_o, busy_o, tbl_en_o, tbl_we_o, tbl_addr_o, tbl_wdata_o},
            {1'b0, 1'b1, 1'b1, 1'b1, 5'(c - 1), 2'b01});
    end
    if (n == int'(N_ENT)) begin
      tick();
      check("init_done", {busy_o, tbl_en_o, lookup_gnt_o}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int stalls;
    int wr_before;
    reset_n_i = 1'b0;
    clear_inputs();
    lookup_idx_f_i = '0;
    tbl_rdata_i = '0;
    for (int i = 0; i < int'(N_ENT); i++) begin
      mem[i] = 2'b11; ref_mem[i] = 2'b01; vis_mem[i] = 2'b01;
    end
    repeat (2) tick();
    check_reset_outs();
    reset_n_i = 1'b1;
    run_init(32);
    mon_en = 1'b1;

    // Freshly initialised entry predicts untaken
    lookup(5'd0, 3);

    // Saturation: four taken updates to idx 3 write 10,11,11,11
    for (int k = 0; k < 4; k++) begin
      push_upd(5'd3, 1'b1, 1'b1);
      tick();
    end
    drain();
    lookup(5'd3, 2);

    // Hazard: queued update to idx 9 stays behind continuous lookups, which see the old value
    lk_idx = 5'd9; lookup_idx_f_i = 5'd9; lookup_vld_f_i = 1'b1;
    push_upd(5'd9, 1'b1, 1'b1);
    stalls = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      branch_op_e_i = 2'b00;
      if (!lookup_gnt_o) stalls++;
    end
    check("hazard_lookup_stalls", 32'(stalls), 32'd0);
    drain();
    lookup(5'd9, 2);

    // Arbitration + overflow: 4th back-to-back push lands on a full FIFO during UPD_WR and is dropped
    lk_idx = 5'd7; lookup_idx_f_i = 5'd7; lookup_vld_f_i = 1'b1;
    stalls = 0;
    for (int c = 0; c < 12; c++) begin
      case (c)
        0: push_upd(5'd10, 1'b1, 1'b1);
        1: push_upd(5'd11, 1'b1, 1'b1);
        2: push_upd(5'd12, 1'b0, 1'b1);
        3: push_upd(5'd13, 1'b1, 1'b0);
        default: branch_op_e_i = 2'b00;
      endcase
      tick();
      if (!lookup_gnt_o) stalls++;
    end
    check("arb_lookup_stalls", 32'(stalls), 32'd4);
    drain();
    lookup(5'd12, 2);
    lookup(5'd13, 2);
`ifdef BP_TABLE_STATS_EN
    check("drop_cnt", 32'(drop_cnt_o), 32'd1);
    check("upd_cnt", 32'(upd_cnt_o), 32'(n_acc));
`endif

    // Op/stall gating: none of these may push or write
    wr_before = n_wr;
    for (int c = 0; c < 6; c++) begin
      case (c % 3)
        0: begin branch_op_e_i = 2'b01; stall_e_i = 1'b1; end
        1: begin branch_op_e_i = 2'b10; stall_e_i = 1'b0; end
        default: begin branch_op_e_i = 2'b00; stall_e_i = 1'b0; end
      endcase
      upd_idx_e_i = 5'(c + 20); pc_src_res_e_i = 1'b1;
      tick();
    end
    clear_inputs();
    repeat (6) tick();
    check("gated_writes", 32'(n_wr - wr_before), 32'd0);
    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    check("updates_written", 32'(n_wr), 32'(n_acc));

    // Reset mid-sweep at init_addr=17 restarts the full sweep from 0
    mon_en = 1'b0;
    reset_n_i = 1'b0;
    #2;
    check_reset_outs();
    tick();
    reset_n_i = 1'b1;
    run_init(17);
    reset_n_i = 1'b0;
    #2;
    check_reset_outs();
    tick();
    reset_n_i = 1'b1;
    run_init(32);
    for (int i = 0; i < int'(N_ENT); i++) begin
      ref_mem[i] = 2'b01; vis_mem[i] = 2'b01;
    end
    prev_gnt = 1'b0;
    mon_en = 1'b1;
    lookup(5'd3, 2);
    lookup(5'd9, 2);
`ifdef BP_TABLE_STATS_EN
    check("stats_after_reset", {upd_cnt_o, drop_cnt_o}, 32'd0);
`endif
    check("pred_queue_empty", 32'(pred_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
